// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase slave multiplexer for six peripheral ports plus an
// internal default slave that answers unmapped transfers with a two-cycle ERROR.
module ahblite_slave_mux #(
    parameter bit Port0_en = 1'b1,
    parameter bit Port1_en = 1'b1,
    parameter bit Port2_en = 1'b1,
    parameter bit Port3_en = 1'b1,
    parameter bit Port4_en = 1'b1,
    parameter bit Port5_en = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P4_HSEL,
    input  logic        P5_HSEL,
    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P4_HREADYOUT,
    input  logic        P5_HREADYOUT,
    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic        P4_HRESP,
    input  logic        P5_HRESP,
    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    input  logic [31:0] P4_HRDATA,
    input  logic [31:0] P5_HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam logic [2:0] SEL_P0   = 3'd0;
    localparam logic [2:0] SEL_P1   = 3'd1;
    localparam logic [2:0] SEL_P2   = 3'd2;
    localparam logic [2:0] SEL_P3   = 3'd3;
    localparam logic [2:0] SEL_P4   = 3'd4;
    localparam logic [2:0] SEL_P5   = 3'd5;
    localparam logic [2:0] SEL_DS   = 3'd6;
    localparam logic [2:0] SEL_NONE = 3'd7;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    logic [5:0] port_en_s;
    logic [5:0] hsel_s;
    logic       ds_load_s;
    logic [2:0] sel_next_s;
    logic [2:0] sel_r;
    ds_state_t  ds_state_r;
    ds_state_t  ds_next_s;
    logic       ds_ready_s;
    logic       ds_resp_s;
    logic       unused_s;

    // A disabled port's select is masked so it decodes as unmapped
    assign port_en_s = {Port5_en, Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};
    assign hsel_s    = {P5_HSEL, P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & port_en_s;
    assign ds_load_s = HREADY & (hsel_s == 6'b000000) & HTRANS[1];
    assign unused_s  = HTRANS[0];

    // Address-phase decode: lowest enabled select wins, else DS or NONE
    always_comb begin
        sel_next_s = SEL_NONE;
        if (hsel_s[0]) begin
            sel_next_s = SEL_P0;
        end else if (hsel_s[1]) begin
            sel_next_s = SEL_P1;
        end else if (hsel_s[2]) begin
            sel_next_s = SEL_P2;
        end else if (hsel_s[3]) begin
            sel_next_s = SEL_P3;
        end else if (hsel_s[4]) begin
            sel_next_s = SEL_P4;
        end else if (hsel_s[5]) begin
            sel_next_s = SEL_P5;
        end else if (HTRANS[1]) begin
            sel_next_s = SEL_DS;
        end else begin
            sel_next_s = SEL_NONE;
        end
    end

    // Data-phase select register, advanced only when the bus is ready
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_r <= SEL_NONE;
        end else if (HREADY) begin
            sel_r <= sel_next_s;
        end
    end

    // Default-slave state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state_r <= DS_IDLE;
        end else begin
            ds_state_r <= ds_next_s;
        end
    end

    // Default-slave next state
    always_comb begin
        ds_next_s = DS_IDLE;
        case (ds_state_r)
            DS_IDLE: ds_next_s = ds_load_s ? DS_ERR1 : DS_IDLE;
            DS_ERR1: ds_next_s = DS_ERR2;
            DS_ERR2: ds_next_s = ds_load_s ? DS_ERR1 : DS_IDLE;
            default: ds_next_s = DS_IDLE;
        endcase
    end

    // Default-slave outputs: stall with ERROR, then complete the ERROR
    always_comb begin
        ds_ready_s = 1'b1;
        ds_resp_s  = 1'b0;
        case (ds_state_r)
            DS_IDLE: begin ds_ready_s = 1'b1; ds_resp_s = 1'b0; end
            DS_ERR1: begin ds_ready_s = 1'b0; ds_resp_s = 1'b1; end
            DS_ERR2: begin ds_ready_s = 1'b1; ds_resp_s = 1'b1; end
            default: begin ds_ready_s = 1'b1; ds_resp_s = 1'b0; end
        endcase
    end

    // Response mux, combinational from the select register
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0000_0000;
        case (sel_r)
            SEL_P0:  begin HREADYOUT = P0_HREADYOUT; HRESP = P0_HRESP; HRDATA = P0_HRDATA; end
            SEL_P1:  begin HREADYOUT = P1_HREADYOUT; HRESP = P1_HRESP; HRDATA = P1_HRDATA; end
            SEL_P2:  begin HREADYOUT = P2_HREADYOUT; HRESP = P2_HRESP; HRDATA = P2_HRDATA; end
            SEL_P3:  begin HREADYOUT = P3_HREADYOUT; HRESP = P3_HRESP; HRDATA = P3_HRDATA; end
            SEL_P4:  begin HREADYOUT = P4_HREADYOUT; HRESP = P4_HRESP; HRDATA = P4_HRDATA; end
            SEL_P5:  begin HREADYOUT = P5_HREADYOUT; HRESP = P5_HRESP; HRDATA = P5_HRDATA; end
            SEL_DS:  begin HREADYOUT = ds_ready_s;   HRESP = ds_resp_s; HRDATA = 32'h0000_0000; end
            default: begin HREADYOUT = 1'b1;         HRESP = 1'b0;      HRDATA = 32'h0000_0000; end
        endcase
    end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Directed bench for ahblite_slave_mux; HREADY is looped back from HREADYOUT
// and port 2 is built disabled.
module tb_ahblite_slave_mux;

    logic        HCLK;
    logic        HRESETn;
    logic        HREADY;
    logic [1:0]  HTRANS;
    logic        P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL, P5_HSEL;
    logic        P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT, P4_HREADYOUT, P5_HREADYOUT;
    logic        P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP, P5_HRESP;
    logic [31:0] P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P4_HRDATA, P5_HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    int n_cmp = 0;
    int n_err = 0;

    assign HREADY = HREADYOUT;

    ahblite_slave_mux #(
        .Port0_en(1'b1), .Port1_en(1'b1), .Port2_en(1'b0),
        .Port3_en(1'b1), .Port4_en(1'b1), .Port5_en(1'b1)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY), .HTRANS(HTRANS),
        .P0_HSEL(P0_HSEL), .P1_HSEL(P1_HSEL), .P2_HSEL(P2_HSEL),
        .P3_HSEL(P3_HSEL), .P4_HSEL(P4_HSEL), .P5_HSEL(P5_HSEL),
        .P0_HREADYOUT(P0_HREADYOUT), .P1_HREADYOUT(P1_HREADYOUT), .P2_HREADYOUT(P2_HREADYOUT),
        .P3_HREADYOUT(P3_HREADYOUT), .P4_HREADYOUT(P4_HREADYOUT), .P5_HREADYOUT(P5_HREADYOUT),
        .P0_HRESP(P0_HRESP), .P1_HRESP(P1_HRESP), .P2_HRESP(P2_HRESP),
        .P3_HRESP(P3_HRESP), .P4_HRESP(P4_HRESP), .P5_HRESP(P5_HRESP),
        .P0_HRDATA(P0_HRDATA), .P1_HRDATA(P1_HRDATA), .P2_HRDATA(P2_HRDATA),
        .P3_HRDATA(P3_HRDATA), .P4_HRDATA(P4_HRDATA), .P5_HRDATA(P5_HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus();
        HTRANS = 2'b00;
        {P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL, P5_HSEL} = 6'b000000;
        {P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT, P4_HREADYOUT, P5_HREADYOUT} = 6'b111111;
        {P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP, P5_HRESP} = 6'b000000;
        P0_HRDATA = 32'h0; P1_HRDATA = 32'h0; P2_HRDATA = 32'h0;
        P3_HRDATA = 32'h0; P4_HRDATA = 32'h0; P5_HRDATA = 32'h0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b1;
        idle_bus();
        #3 HRESETn = 1'b0;
        #1;
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin n_err++;
            $display("FAIL reset_out: got rdy=%b resp=%b data=%h want 1 0 00000000", HREADYOUT, HRESP, HRDATA); end
        #2 HRESETn = 1'b1;
        cyc();
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin n_err++;
            $display("FAIL post_reset_idle: got rdy=%b resp=%b data=%h want 1 0 00000000", HREADYOUT, HRESP, HRDATA); end
    endtask

    task automatic test_read();
        P1_HSEL = 1'b1; HTRANS = 2'b10; P1_HRDATA = 32'h12345678; P1_HREADYOUT = 1'b1;
        #1;
        n_cmp++; if (HRDATA !== 32'h0) begin n_err++;
            $display("FAIL read_addr_phase_data: got %h want 00000000", HRDATA); end
        cyc();
        P1_HSEL = 1'b0; HTRANS = 2'b00;
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h12345678}) begin n_err++;
            $display("FAIL read_data_phase: got rdy=%b resp=%b data=%h want 1 0 12345678", HREADYOUT, HRESP, HRDATA); end
        cyc();
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin n_err++;
            $display("FAIL read_return_none: got rdy=%b resp=%b data=%h want 1 0 00000000", HREADYOUT, HRESP, HRDATA); end
        idle_bus();
    endtask

    task automatic test_priority();
        P0_HRDATA = 32'hA0A0A0A0; P1_HRDATA = 32'hB1B1B1B1; P3_HRDATA = 32'hC3C3C3C3;
        P0_HSEL = 1'b1; P1_HSEL = 1'b1; HTRANS = 2'b10;
        cyc();
        P0_HSEL = 1'b0; P1_HSEL = 1'b0; P2_HSEL = 1'b1; P3_HSEL = 1'b1;
        n_cmp++; if (HRDATA !== 32'hA0A0A0A0) begin n_err++;
            $display("FAIL priority_p0_over_p1: got %h want a0a0a0a0", HRDATA); end
        cyc();
        P2_HSEL = 1'b0; P3_HSEL = 1'b0; HTRANS = 2'b00;
        n_cmp++; if (HRDATA !== 32'hC3C3C3C3) begin n_err++;
            $display("FAIL priority_skip_disabled_p2: got %h want c3c3c3c3", HRDATA); end
        cyc();
        idle_bus();
    endtask

    task automatic test_wait_hold();
        P3_HRDATA = 32'h33333333; P5_HRDATA = 32'h55555555;
        P3_HSEL = 1'b1; HTRANS = 2'b10; P3_HREADYOUT = 1'b0;
        cyc();
        P3_HSEL = 1'b0; P5_HSEL = 1'b1;
        for (int w = 0; w < 3; w++) begin
            if (w > 0) cyc();
            n_cmp++; if ({HREADYOUT, HRDATA} !== {1'b0, 32'h33333333}) begin n_err++;
                $display("FAIL wait_hold_%0d: got rdy=%b data=%h want 0 33333333", w, HREADYOUT, HRDATA); end
        end
        P3_HREADYOUT = 1'b1;
        #1;
        n_cmp++; if ({HREADYOUT, HRDATA} !== {1'b1, 32'h33333333}) begin n_err++;
            $display("FAIL wait_release: got rdy=%b data=%h want 1 33333333", HREADYOUT, HRDATA); end
        cyc();
        P5_HSEL = 1'b0; HTRANS = 2'b00;
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h55555555}) begin n_err++;
            $display("FAIL wait_p5_after: got rdy=%b resp=%b data=%h want 1 0 55555555", HREADYOUT, HRESP, HRDATA); end
        cyc();
        idle_bus();
    endtask

    task automatic test_unmapped();
        HTRANS = 2'b10;
        cyc();
        HTRANS = 2'b11;
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b0, 1'b1, 32'h0}) begin n_err++;
            $display("FAIL unmapped_err1: got rdy=%b resp=%b data=%h want 0 1 00000000", HREADYOUT, HRESP, HRDATA); end
        cyc();
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b1, 32'h0}) begin n_err++;
            $display("FAIL unmapped_err2: got rdy=%b resp=%b data=%h want 1 1 00000000", HREADYOUT, HRESP, HRDATA); end
        cyc();
        HTRANS = 2'b00;
        n_cmp++; if ({HREADYOUT, HRESP} !== {1'b0, 1'b1}) begin n_err++;
            $display("FAIL unmapped_repeat_err1: got rdy=%b resp=%b want 0 1", HREADYOUT, HRESP); end
        cyc();
        n_cmp++; if ({HREADYOUT, HRESP} !== {1'b1, 1'b1}) begin n_err++;
            $display("FAIL unmapped_repeat_err2: got rdy=%b resp=%b want 1 1", HREADYOUT, HRESP); end
        cyc();
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin n_err++;
            $display("FAIL unmapped_back_idle: got rdy=%b resp=%b data=%h want 1 0 00000000", HREADYOUT, HRESP, HRDATA); end
        idle_bus();
    endtask

    task automatic test_idle();
        for (int k = 0; k < 4; k++) begin
            HTRANS = (k[0] == 1'b1) ? 2'b01 : 2'b00;
            cyc();
            n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin n_err++;
                $display("FAIL idle_%0d: got rdy=%b resp=%b data=%h want 1 0 00000000", k, HREADYOUT, HRESP, HRDATA); end
        end
        idle_bus();
    endtask

    task automatic test_disabled_port();
        P2_HSEL = 1'b1; HTRANS = 2'b10; P2_HRDATA = 32'hDEADBEEF; P2_HREADYOUT = 1'b1;
        cyc();
        P2_HSEL = 1'b0; HTRANS = 2'b00;
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b0, 1'b1, 32'h0}) begin n_err++;
            $display("FAIL disabled_err1: got rdy=%b resp=%b data=%h want 0 1 00000000", HREADYOUT, HRESP, HRDATA); end
        cyc();
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b1, 32'h0}) begin n_err++;
            $display("FAIL disabled_err2: got rdy=%b resp=%b data=%h want 1 1 00000000", HREADYOUT, HRESP, HRDATA); end
        cyc();
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin n_err++;
            $display("FAIL disabled_done: got rdy=%b resp=%b data=%h want 1 0 00000000", HREADYOUT, HRESP, HRDATA); end
        idle_bus();
    endtask

    task automatic test_back_to_back();
        P1_HRDATA = 32'h11110001; P4_HRDATA = 32'h44440004; P0_HRDATA = 32'h00000A0A;
        P1_HSEL = 1'b1; HTRANS = 2'b10;
        cyc();
        P1_HSEL = 1'b0; P4_HSEL = 1'b1; HTRANS = 2'b11;
        n_cmp++; if (HRDATA !== 32'h11110001) begin n_err++;
            $display("FAIL b2b_p1: got %h want 11110001", HRDATA); end
        cyc();
        P4_HSEL = 1'b0; P0_HSEL = 1'b1; HTRANS = 2'b10; P4_HRESP = 1'b1; P4_HREADYOUT = 1'b0;
        #1;
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b0, 1'b1, 32'h44440004}) begin n_err++;
            $display("FAIL b2b_p4_resp: got rdy=%b resp=%b data=%h want 0 1 44440004", HREADYOUT, HRESP, HRDATA); end
        P4_HREADYOUT = 1'b1;
        cyc();
        P0_HSEL = 1'b0; HTRANS = 2'b00;
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h00000A0A}) begin n_err++;
            $display("FAIL b2b_p0: got rdy=%b resp=%b data=%h want 1 0 00000a0a", HREADYOUT, HRESP, HRDATA); end
        cyc();
        // ERR2 completes and a mapped slave follows immediately
        HTRANS = 2'b10;
        cyc();
        HTRANS = 2'b00;
        cyc();
        P1_HSEL = 1'b1; HTRANS = 2'b10;
        cyc();
        P1_HSEL = 1'b0; HTRANS = 2'b00;
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h11110001}) begin n_err++;
            $display("FAIL b2b_err_then_p1: got rdy=%b resp=%b data=%h want 1 0 11110001", HREADYOUT, HRESP, HRDATA); end
        cyc();
        idle_bus();
    endtask

    task automatic test_async_reset();
        HTRANS = 2'b10;
        cyc();
        n_cmp++; if ({HREADYOUT, HRESP} !== {1'b0, 1'b1}) begin n_err++;
            $display("FAIL areset_enter_err1: got rdy=%b resp=%b want 0 1", HREADYOUT, HRESP); end
        #2 HRESETn = 1'b0;
        #1;
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin n_err++;
            $display("FAIL areset_immediate: got rdy=%b resp=%b data=%h want 1 0 00000000", HREADYOUT, HRESP, HRDATA); end
        HTRANS = 2'b00;
        #2 HRESETn = 1'b1;
        cyc();
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin n_err++;
            $display("FAIL areset_after_release: got rdy=%b resp=%b data=%h want 1 0 00000000", HREADYOUT, HRESP, HRDATA); end
        P5_HRDATA = 32'h5A5A5A5A; P5_HSEL = 1'b1; HTRANS = 2'b10;
        cyc();
        P5_HSEL = 1'b0; HTRANS = 2'b00;
        #2 HRESETn = 1'b0;
        #1;
        n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin n_err++;
            $display("FAIL areset_mid_slave: got rdy=%b resp=%b data=%h want 1 0 00000000", HREADYOUT, HRESP, HRDATA); end
        #2 HRESETn = 1'b1;
        cyc();
        idle_bus();
    endtask

    initial begin
        test_reset();
        test_read();
        test_priority();
        test_wait_hold();
        test_unmapped();
        test_idle();
        test_disabled_port();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahblite_slave_mux.md
AHBLITE_SLAVE_MUX -- requirements
Module: ahblite_slave_mux

Interface
REQ-001 SHALL have parameter Port0_en, default 1, RAMCODE port enable; 0 means P0 inputs are ignored and port is treated as unmapped.
REQ-002 SHALL have parameter Port1_en, default 1, RAMDATA port enable, same rule as REQ-001.
REQ-003 SHALL have parameters Port2_en..Port5_en, default 1, LCD/UART/Camera/Buzzer port enables, same rule as REQ-001.
REQ-004 SHALL have port HCLK  input  1  bus clock; the only clock.
REQ-005 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port HREADY  input  1  bus-level ready, fed back from this block's HREADYOUT by the top level.
REQ-007 SHALL have port HTRANS  input  2  master transfer type, address phase.
REQ-008 SHALL have ports P0_HSEL..P5_HSEL  input  1 each  address-phase selects from the decoder.
REQ-009 SHALL have ports P0_HREADYOUT..P5_HREADYOUT  input  1 each  slave ready.
REQ-010 SHALL have ports P0_HRESP..P5_HRESP  input  1 each  slave response; 1 = ERROR.
REQ-011 SHALL have ports P0_HRDATA..P5_HRDATA  input  32 each  slave read data.
REQ-012 SHALL have port HREADYOUT  output  1  muxed ready to master and all slaves.
REQ-013 SHALL have port HRESP  output  1  muxed response to master.
REQ-014 SHALL have port HRDATA  output  32  muxed read data to master.

Function
REQ-015 SHALL hold a data-phase select register covering 7 targets: P0..P5 plus an internal default slave (DS), plus a NONE encoding.
REQ-016 SHALL update the select register only on HCLK rising edges where HREADY=1; it SHALL hold its value while HREADY=0.
REQ-017 SHALL load the lowest-index PN with PN_HSEL=1 and PortN_en=1; if several are asserted, the lowest index wins.
REQ-018 SHALL load DS when no enabled PN_HSEL is asserted and HTRANS[1]=1 (NONSEQ or SEQ).
REQ-019 SHALL load NONE when no enabled PN_HSEL is asserted and HTRANS[1]=0 (IDLE or BUSY).
REQ-020 SHALL drive HREADYOUT/HRESP/HRDATA from PN_HREADYOUT/PN_HRESP/PN_HRDATA when the register holds PN, with zero added latency (combinational from the register).
REQ-021 SHALL drive HREADYOUT=1, HRESP=0, HRDATA=0 when the register holds NONE.
REQ-022 SHALL implement the DS FSM with states DS_IDLE, DS_ERR1 and DS_ERR2.
REQ-023 SHALL move the DS FSM from DS_IDLE to DS_ERR1 when DS is loaded per REQ-018.
REQ-024 SHALL move the DS FSM from DS_ERR1 to DS_ERR2 unconditionally on the next edge.
REQ-025 SHALL move the DS FSM from DS_ERR2 to DS_ERR1 if another unmapped NONSEQ/SEQ is sampled; otherwise it SHALL return to DS_IDLE.
REQ-026 SHALL output HREADYOUT=0, HRESP=1, HRDATA=0 in DS_ERR1, and HREADYOUT=1, HRESP=1, HRDATA=0 in DS_ERR2 (two-cycle AHB ERROR response).
REQ-027 SHALL keep the selected slave's outputs on HREADYOUT for every wait state; back-to-back transfers to different slaves SHALL switch data-phase source exactly one cycle after the address phase.
REQ-028 SHALL pass PN_HRESP=1 from a selected slave through unchanged; the block adds no extra cycles to it.

Reset
REQ-029 SHALL, on HRESETn=0 and independent of HCLK, force the select register to NONE and the DS FSM to DS_IDLE, giving HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-030 SHALL, if reset is asserted mid-transfer (including in DS_ERR1), abandon that transfer, with outputs per REQ-029 at the first rising HCLK edge after HRESETn=1.

Verification
REQ-031 SHALL verify read decode: P1_HSEL=1, HTRANS=NONSEQ, HREADY=1 at edge n, P1_HRDATA=0x12345678, P1_HREADYOUT=1 -> in cycle n+1 HRDATA=0x12345678, HREADYOUT=1, HRESP=0.
REQ-032 SHALL verify wait-state hold: P3 selected, P3_HREADYOUT=0 for 3 cycles, P5_HSEL=1 during the wait -> HREADYOUT=0 for 3 cycles, P5 not loaded until HREADY=1, then P5 data appears the following cycle.
REQ-033 SHALL verify the unmapped error: all HSEL=0, HTRANS=NONSEQ -> next cycle HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then HRESP=0 if HTRANS=IDLE.
REQ-034 SHALL verify idle and unmapped IDLE: all HSEL=0, HTRANS=IDLE -> HREADYOUT=1, HRESP=0, HRDATA=0 every cycle, with no FSM transition.
REQ-035 SHALL verify a disabled port: Port2_en=0, P2_HSEL=1, HTRANS=NONSEQ -> DS ERROR response; P2_HRDATA=0xDEADBEEF never appears on HRDATA.
REQ-036 SHALL verify async reset: HRESETn pulled low between edges while in DS_ERR1 -> HREADYOUT=1, HRESP=0 immediately, with no HCLK edge required.
